// File: rtl/sprite_pixel_pipeline.sv
// ----------------------------------------------------------------------------
// sprite_pixel_pipeline
//
// Purpose:
//   Turns the raster position coming from the line counters into sprite-ROM
//   addresses and registered RGB444 pixels for the VGA DAC, and moves the
//   sprite by at most one step per frame from the latched controller state.
//   The sprite position only changes during vertical blanking, so a visible
//   frame is always drawn with a single, stable position.
//
// Ports:
//   clock_i        pixel clock (25 MHz)
//   reset_ni       synchronous, active-low reset
//   h_count_i      horizontal pixel count, 0..799
//   v_count_i      vertical line count, 0..524
//   buttons_i      {up, down, left, right}, active-high, latched controller
//   rom_addr_o     sprite ROM address, registered
//   rom_data_i     RGB444 from the synchronous ROM, valid 1 clock after addr
//   rgb_o          pixel colour, registered
//   pixel_valid_o  display enable, aligned with rgb_o
//   sprite_x_o     sprite left column
//   sprite_y_o     sprite top line
//
// Pipeline timing (edge N samples the raster position):
//   N   : h/v captured
//   N+1 : rom_addr, hit, vis registered
//   N+2 : ROM presents rom_data; hit/vis delayed one more stage
//   N+3 : rgb and pixel_valid registered
// ----------------------------------------------------------------------------
module sprite_pixel_pipeline #(
    parameter int          H_VISIBLE   = 640,
    parameter int          V_VISIBLE   = 480,
    parameter int          SPRITE_W    = 32,     // must be a power of 2
    parameter int          SPRITE_H    = 32,
    parameter int          STEP        = 2,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    localparam int         ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic [9:0]        h_count_i,
    input  logic [9:0]        v_count_i,
    input  logic [3:0]        buttons_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [11:0]       rom_data_i,
    output logic [11:0]       rgb_o,
    output logic              pixel_valid_o,
    output logic [9:0]        sprite_x_o,
    output logic [9:0]        sprite_y_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [9:0] X_MAX   = 10'(H_VISIBLE - SPRITE_W);
    localparam logic [9:0] Y_MAX   = 10'(V_VISIBLE - SPRITE_H);
    localparam logic [9:0] X_INIT  = 10'((H_VISIBLE - SPRITE_W) / 2);
    localparam logic [9:0] Y_INIT  = 10'((V_VISIBLE - SPRITE_H) / 2);
    localparam int         X_SHIFT = $clog2(SPRITE_W);

    // Button bit positions inside buttons_i.
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    typedef enum logic [1:0] {
        ARMED = 2'd0,   // waiting for the start of vertical blanking
        MOVE  = 2'd1,   // one-clock window in which the position is updated
        DONE  = 2'd2    // moved this frame; wait for the frame to wrap
    } state_e;

    // ------------------------------------------------------------------------
    // Motion state
    // ------------------------------------------------------------------------
    state_e     state_q,    state_d;
    logic [3:0] btn_q,      btn_d;
    logic [9:0] sprite_x_q, sprite_x_d;
    logic [9:0] sprite_y_q, sprite_y_d;

    // ------------------------------------------------------------------------
    // Pixel pipeline state
    // ------------------------------------------------------------------------
    // Stage 0: captured raster position. s0_vld_q keeps the zero position
    // left behind by reset from being treated as a real visible pixel.
    logic              s0_vld_q;
    logic [9:0]        h_q;
    logic [9:0]        v_q;

    // Stage 1: address and classification.
    logic              vis_d,  hit_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              vis1_q, hit1_q;

    // Stage 2: aligned with rom_data_i.
    logic              vis2_q, hit2_q;

    // Stage 3: output pixel.
    logic [11:0]       rgb_q,  rgb_d;
    logic              pixel_valid_q;

    // ------------------------------------------------------------------------
    // Saturating single-axis step. dec moves towards 0, inc towards max_pos;
    // both or neither leave the position unchanged.
    // ------------------------------------------------------------------------
    function automatic logic [9:0] step_axis(
        input logic [9:0] pos,
        input logic       dec,
        input logic       inc,
        input logic [9:0] max_pos
    );
        logic [10:0] up_sum;
        logic [9:0]  result;
        result = pos;
        up_sum = {1'b0, pos} + 11'(STEP);
        if (inc && !dec) begin
            result = (up_sum > {1'b0, max_pos}) ? max_pos : up_sum[9:0];
        end else if (dec && !inc) begin
            result = (pos < 10'(STEP)) ? 10'd0 : pos - 10'(STEP);
        end
        return result;
    endfunction

    // ------------------------------------------------------------------------
    // Motion FSM: next state and position
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        btn_d      = btn_q;
        sprite_x_d = sprite_x_q;
        sprite_y_d = sprite_y_q;

        case (state_q)
            ARMED: begin
                // First blanking line, first pixel: latch the controller here
                // so the move uses one consistent snapshot of the buttons.
                if (v_count_i == 10'(V_VISIBLE) && h_count_i == 10'd0) begin
                    state_d = MOVE;
                    btn_d   = buttons_i;
                end
            end
            MOVE: begin
                state_d    = DONE;
                sprite_x_d = step_axis(sprite_x_q, btn_q[BTN_LEFT],
                                       btn_q[BTN_RIGHT], X_MAX);
                sprite_y_d = step_axis(sprite_y_q, btn_q[BTN_UP],
                                       btn_q[BTN_DOWN], Y_MAX);
            end
            DONE: begin
                if (v_count_i == 10'd0) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, regardless of the
    // order the statements appear in.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q    <= ARMED;
            btn_q      <= 4'd0;
            sprite_x_q <= X_INIT;
            sprite_y_q <= Y_INIT;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            sprite_x_q <= sprite_x_d;
            sprite_y_q <= sprite_y_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 combinational: visibility, sprite hit and ROM address
    // ------------------------------------------------------------------------
    logic        in_x, in_y;
    logic [9:0]  dx, dy;

    always_comb begin
        vis_d = s0_vld_q && (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));

        // One extra bit so sprite_x + SPRITE_W cannot wrap near the edge.
        in_x  = ({1'b0, h_q} >= {1'b0, sprite_x_q}) &&
                ({1'b0, h_q} <  ({1'b0, sprite_x_q} + 11'(SPRITE_W)));
        in_y  = ({1'b0, v_q} >= {1'b0, sprite_y_q}) &&
                ({1'b0, v_q} <  ({1'b0, sprite_y_q} + 11'(SPRITE_H)));
        hit_d = vis_d && in_x && in_y;

        // The offsets are only meaningful under hit, where they cannot wrap.
        dx = h_q - sprite_x_q;
        dy = v_q - sprite_y_q;

        rom_addr_d = '0;
        if (hit_d) begin
            // SPRITE_W is a power of 2, so row * SPRITE_W is a shift.
            rom_addr_d = ADDR_W'((32'(dy) << X_SHIFT) + 32'(dx));
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3 combinational: colour selection
    // ------------------------------------------------------------------------
    always_comb begin
        rgb_d = 12'h000;
        if (vis2_q) begin
            if (hit2_q && (rom_data_i != TRANSPARENT)) begin
                rgb_d = rom_data_i;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            s0_vld_q      <= 1'b0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            rom_addr_q    <= '0;
            vis1_q        <= 1'b0;
            hit1_q        <= 1'b0;
            vis2_q        <= 1'b0;
            hit2_q        <= 1'b0;
            rgb_q         <= 12'h000;
            pixel_valid_q <= 1'b0;
        end else begin
            s0_vld_q      <= 1'b1;
            h_q           <= h_count_i;
            v_q           <= v_count_i;
            rom_addr_q    <= rom_addr_d;
            vis1_q        <= vis_d;
            hit1_q        <= hit_d;
            vis2_q        <= vis1_q;
            hit2_q        <= hit1_q;
            rgb_q         <= rgb_d;
            pixel_valid_q <= vis2_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr_o    = rom_addr_q;
    assign rgb_o         = rgb_q;
    assign pixel_valid_o = pixel_valid_q;
    assign sprite_x_o    = sprite_x_q;
    assign sprite_y_o    = sprite_y_q;

endmodule
